// File: rtl/io_buffer.sv
// io_buffer: CPU-facing output and input byte FIFOs with valid/ready external handshakes.
// Optional feature: define IO_LOOPBACK_EN to add the loopback port, which routes the
// output FIFO head straight into the input FIFO instead of the external pins.
module io_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_wr,
  input  logic [WIDTH-1:0]         cpu_wdata,
  input  logic                     cpu_rd,
  output logic [WIDTH-1:0]         cpu_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic [$clog2(DEPTH):0]   in_count,
  output logic                     ovf,
  output logic                     udf,
`ifdef IO_LOOPBACK_EN
  input  logic                     loopback,
`endif
  input  logic                     err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] out_mem_q [DEPTH];
  logic [WIDTH-1:0] in_mem_q  [DEPTH];
  logic [AW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic [AW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, in_cnt_q, in_cnt_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic lb, lb_xfer;
  logic out_empty, out_full, in_empty, in_full;
  logic out_push, out_pop, in_push, in_pop;
  logic [WIDTH-1:0] out_head, in_head, in_wdata;
`ifdef IO_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif
  assign out_empty = out_cnt_q == '0;
  assign out_full  = out_cnt_q == FULL;
  assign in_empty  = in_cnt_q == '0;
  assign in_full   = in_cnt_q == FULL;
  assign out_head  = out_mem_q[out_rp_q];
  assign in_head   = in_mem_q[in_rp_q];
  // Handshake flags come only from registered counts; the reset gate keeps in_ready low while held.
  assign out_valid = !out_empty && !lb;
  assign in_ready  = reset && !in_full && !lb;
  assign out_data  = out_empty ? '0 : out_head;
  assign cpu_rdata = in_empty ? '0 : in_head;
  assign out_count = out_cnt_q;
  assign in_count  = in_cnt_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  // Push/pop decisions from pre-edge occupancy, plus next-state for pointers, counts and sticky errors.
  always_comb begin
    lb_xfer   = lb && !out_empty && !in_full;
    out_push  = cpu_wr && !out_full;
    out_pop   = (out_valid && out_ready) || lb_xfer;
    in_push   = (in_valid && in_ready) || lb_xfer;
    in_pop    = cpu_rd && !in_empty;
    in_wdata  = lb ? out_head : in_data;
    out_wp_d  = out_push ? out_wp_q + AW'(1) : out_wp_q;
    out_rp_d  = out_pop ? out_rp_q + AW'(1) : out_rp_q;
    in_wp_d   = in_push ? in_wp_q + AW'(1) : in_wp_q;
    in_rp_d   = in_pop ? in_rp_q + AW'(1) : in_rp_q;
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
    ovf_d     = (cpu_wr && out_full) || (ovf_q && !err_clr);
    udf_d     = (cpu_rd && in_empty) || (udf_q && !err_clr);
  end
  // Control state; an asserted reset discards buffered bytes at once by zeroing pointers and counts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      out_cnt_q <= '0;
      in_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      out_wp_q  <= out_wp_d;
      out_rp_q  <= out_rp_d;
      in_wp_q   <= in_wp_d;
      in_rp_q   <= in_rp_d;
      out_cnt_q <= out_cnt_d;
      in_cnt_q  <= in_cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end
  // Storage is left unreset; stale entries are never visible because empty heads read as zero.
  always_ff @(posedge clock) begin
    if (out_push) out_mem_q[out_wp_q] <= cpu_wdata;
    if (in_push) in_mem_q[in_wp_q] <= in_wdata;
  end
endmodule

// File: tb/tb_io_buffer.sv
// tb_io_buffer: directed self-checking bench for io_buffer (loopback scenario with IO_LOOPBACK_EN).
module tb_io_buffer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic cpu_wr = 1'b0, cpu_rd = 1'b0, out_ready = 1'b0, in_valid = 1'b0, err_clr = 1'b0;
  logic [7:0] cpu_wdata = 8'h00, in_data = 8'h00;
  logic [7:0] cpu_rdata, out_data;
  logic out_valid, in_ready, ovf, udf;
  logic [2:0] out_count, in_count;
`ifdef IO_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  int passed = 0;
  int total = 0;

  io_buffer #(.DEPTH(4), .WIDTH(8)) dut (
    .clock(clock), .reset(reset), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd),
    .cpu_rdata(cpu_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_count(out_count),
    .in_count(in_count), .ovf(ovf), .udf(udf),
`ifdef IO_LOOPBACK_EN
    .loopback(loopback),
`endif
    .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_held: got %b expected 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid_held: got %b expected 0", out_valid); else passed++;
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_release: got %b expected 1", in_ready); else passed++;
    total++; if (out_count !== 3'd0) $display("FAIL rst_out_count_release: got %0d expected 0", out_count); else passed++;
    tick;
    cpu_wr = 1'b1; cpu_wdata = 8'h77; in_valid = 1'b1; in_data = 8'h66; cpu_rd = 1'b1;
    tick;
    cpu_wr = 1'b0; in_valid = 1'b0; cpu_rd = 1'b0;
    total++; if (out_count !== 3'd1) $display("FAIL mid_out_count: got %0d expected 1", out_count); else passed++;
    total++; if (in_count !== 3'd1) $display("FAIL mid_in_count: got %0d expected 1", in_count); else passed++;
    total++; if (udf !== 1'b1) $display("FAIL mid_udf: got %b expected 1", udf); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (out_count !== 3'd0) $display("FAIL async_out_count: got %0d expected 0", out_count); else passed++;
    total++; if (in_count !== 3'd0) $display("FAIL async_in_count: got %0d expected 0", in_count); else passed++;
    total++; if (udf !== 1'b0) $display("FAIL async_udf: got %b expected 0", udf); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL async_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL async_in_ready: got %b expected 0", in_ready); else passed++;
    total++; if (cpu_rdata !== 8'h00) $display("FAIL async_cpu_rdata: got %h expected 00", cpu_rdata); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL async_out_data: got %h expected 00", out_data); else passed++;
    reset = 1'b1;
    tick;
    total++; if (in_ready !== 1'b1) $display("FAIL rerelease_in_ready: got %b expected 1", in_ready); else passed++;
  endtask

  task automatic test_out_order;
    out_ready = 1'b0;
    cpu_wr = 1'b1; cpu_wdata = 8'h11;
    total++; if (out_valid !== 1'b0) $display("FAIL order_no_fallthrough: got %b expected 0", out_valid); else passed++;
    tick;
    total++; if (out_valid !== 1'b1) $display("FAIL order_valid_after_edge: got %b expected 1", out_valid); else passed++;
    cpu_wdata = 8'h22;
    tick;
    cpu_wdata = 8'h33;
    tick;
    cpu_wr = 1'b0;
    total++; if (out_count !== 3'd3) $display("FAIL order_count: got %0d expected 3", out_count); else passed++;
    total++; if (out_data !== 8'h11) $display("FAIL order_head0: got %h expected 11", out_data); else passed++;
    out_ready = 1'b1;
    tick;
    total++; if (out_data !== 8'h22) $display("FAIL order_head1: got %h expected 22", out_data); else passed++;
    tick;
    total++; if (out_data !== 8'h33) $display("FAIL order_head2: got %h expected 33", out_data); else passed++;
    tick;
    total++; if (out_valid !== 1'b0) $display("FAIL order_drained_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL order_drained_data: got %h expected 00", out_data); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_wr = 1'b1; cpu_wdata = 8'hA0 + 8'(i);
      tick;
    end
    cpu_wr = 1'b0;
    total++; if (out_count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", out_count); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", ovf); else passed++;
    total++; if (out_data !== 8'hA0) $display("FAIL ovf_head0: got %h expected a0", out_data); else passed++;
    cpu_wr = 1'b1; cpu_wdata = 8'hEE; out_ready = 1'b1;
    tick;
    cpu_wr = 1'b0;
    total++; if (out_count !== 3'd3) $display("FAIL ovf_full_pop_count: got %0d expected 3", out_count); else passed++;
    total++; if (out_data !== 8'hA1) $display("FAIL ovf_head1: got %h expected a1", out_data); else passed++;
    tick;
    total++; if (out_data !== 8'hA2) $display("FAIL ovf_head2: got %h expected a2", out_data); else passed++;
    tick;
    total++; if (out_data !== 8'hA3) $display("FAIL ovf_head3: got %h expected a3", out_data); else passed++;
    tick;
    total++; if (out_valid !== 1'b0) $display("FAIL ovf_dropped_write: got %b expected 0", out_valid); else passed++;
    out_ready = 1'b0; err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    total++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", ovf); else passed++;
  endtask

  task automatic test_underflow;
    cpu_rd = 1'b1;
    tick;
    cpu_rd = 1'b0;
    total++; if (cpu_rdata !== 8'h00) $display("FAIL udf_rdata: got %h expected 00", cpu_rdata); else passed++;
    total++; if (udf !== 1'b1) $display("FAIL udf_set: got %b expected 1", udf); else passed++;
    total++; if (in_count !== 3'd0) $display("FAIL udf_count: got %0d expected 0", in_count); else passed++;
    err_clr = 1'b1;
    tick;
    total++; if (udf !== 1'b0) $display("FAIL udf_clear: got %b expected 0", udf); else passed++;
    cpu_rd = 1'b1;
    tick;
    cpu_rd = 1'b0;
    total++; if (udf !== 1'b1) $display("FAIL udf_set_wins: got %b expected 1", udf); else passed++;
    tick;
    err_clr = 1'b0;
    total++; if (udf !== 1'b0) $display("FAIL udf_final_clear: got %b expected 0", udf); else passed++;
  endtask

  task automatic test_in_wrap;
    int m = 0;
    int wr_next = 1;
    int rd_next = 1;
    bit push, pop;
    for (int c = 0; c < 40 && rd_next <= 10; c++) begin
      in_valid = (wr_next <= 10);
      in_data = 8'(wr_next);
      cpu_rd = (c >= 4) && (c != 7);
      #1;
      total++; if (in_ready !== (m != 4)) $display("FAIL wrap_in_ready c%0d: got %b expected %b", c, in_ready, m != 4); else passed++;
      total++; if (in_count !== 3'(m)) $display("FAIL wrap_count c%0d: got %0d expected %0d", c, in_count, m); else passed++;
      total++; if (cpu_rdata !== (m != 0 ? 8'(rd_next) : 8'h00)) $display("FAIL wrap_rdata c%0d: got %h expected %h", c, cpu_rdata, m != 0 ? 8'(rd_next) : 8'h00); else passed++;
      push = in_valid && (m != 4);
      pop = cpu_rd && (m != 0);
      tick;
      if (push) wr_next++;
      if (pop) rd_next++;
      m = m + int'(push) - int'(pop);
    end
    in_valid = 1'b0; cpu_rd = 1'b0;
    total++; if (rd_next !== 11) $display("FAIL wrap_all_read: got %0d expected 11", rd_next); else passed++;
    total++; if (in_count !== 3'd0) $display("FAIL wrap_final_count: got %0d expected 0", in_count); else passed++;
    total++; if (udf !== 1'b0) $display("FAIL wrap_no_udf: got %b expected 0", udf); else passed++;
  endtask

`ifdef IO_LOOPBACK_EN
  task automatic test_loopback;
    loopback = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    cpu_wr = 1'b1; cpu_wdata = 8'h5A;
    tick;
    cpu_wdata = 8'hC3;
    total++; if (out_valid !== 1'b0) $display("FAIL lb_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL lb_in_ready: got %b expected 0", in_ready); else passed++;
    tick;
    cpu_wr = 1'b0;
    total++; if (cpu_rdata !== 8'h5A) $display("FAIL lb_first: got %h expected 5a", cpu_rdata); else passed++;
    tick;
    total++; if (in_count !== 3'd2) $display("FAIL lb_in_count: got %0d expected 2", in_count); else passed++;
    total++; if (out_count !== 3'd0) $display("FAIL lb_out_count: got %0d expected 0", out_count); else passed++;
    cpu_rd = 1'b1;
    tick;
    total++; if (cpu_rdata !== 8'hC3) $display("FAIL lb_second: got %h expected c3", cpu_rdata); else passed++;
    tick;
    cpu_rd = 1'b0; in_valid = 1'b0; loopback = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL lb_off_in_ready: got %b expected 1", in_ready); else passed++;
    in_valid = 1'b1; in_data = 8'h99; cpu_wr = 1'b1; cpu_wdata = 8'h42;
    tick;
    in_valid = 1'b0; cpu_wr = 1'b0;
    total++; if (cpu_rdata !== 8'h99) $display("FAIL lb_off_in_data: got %h expected 99", cpu_rdata); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL lb_off_out_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_data !== 8'h42) $display("FAIL lb_off_out_data: got %h expected 42", out_data); else passed++;
  endtask
`endif

  task automatic test_back_to_back;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_wr = 1'b1; cpu_wdata = 8'h30 + 8'(i);
      tick;
      total++; if (out_data !== 8'h30 + 8'(i)) $display("FAIL b2b_head%0d: got %h expected %h", i, out_data, 8'h30 + 8'(i)); else passed++;
      total++; if (out_count !== 3'd1) $display("FAIL b2b_count%0d: got %0d expected 1", i, out_count); else passed++;
    end
    cpu_wr = 1'b0;
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", out_valid); else passed++;
  endtask

  initial begin
    test_reset;
    test_out_order;
    test_overflow;
    test_underflow;
    test_in_wrap;
`ifdef IO_LOOPBACK_EN
    test_loopback;
`endif
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/io_buffer.md
# io_buffer

Buffered I/O block that replaces the CPU's bare `cpuin`/`cpuout` byte wires. It sits directly downstream of the CPU's bus logic, where register `110` is accessed, and upstream of external devices. It holds two independent FIFOs:
- an output FIFO, which the CPU fills and the external side drains with a valid/ready handshake;
- an input FIFO, which the external side fills and the CPU drains.

Overflow and underflow errors are sticky, and both FIFO occupancies are visible as status.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `WIDTH`, 8: data width in bits.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_wr`  in  1  one-cycle strobe that pushes `cpu_wdata` into the output FIFO.
- `cpu_wdata`  in  WIDTH  byte written by the CPU.
- `cpu_rd`  in  1  one-cycle strobe that pops the input FIFO head.
- `cpu_rdata`  out  WIDTH  input FIFO head; 0 when empty.
- `out_valid`  out  1  output FIFO not empty.
- `out_ready`  in  1  external sink accepts `out_data`.
- `out_data`  out  WIDTH  output FIFO head; 0 when empty.
- `in_valid`  in  1  external source presents `in_data`.
- `in_ready`  out  1  input FIFO not full.
- `in_data`  in  WIDTH  byte from the external source.
- `out_count`  out  $clog2(DEPTH)+1  output FIFO occupancy.
- `in_count`  out  $clog2(DEPTH)+1  input FIFO occupancy.
- `ovf`  out  1  sticky flag: a CPU write was dropped because the output FIFO was full.
- `udf`  out  1  sticky flag: the CPU read an empty input FIFO.
- `err_clr`  in  1  clears `ovf` and `udf`.
- `loopback`  in  1  internal loopback select; present only with `IO_LOOPBACK_EN`.

## Operation
- Each FIFO is a circular buffer with read and write pointers of $clog2(DEPTH) bits, plus a separate occupancy counter.
  - Pointers wrap from DEPTH-1 to 0.
  - The counter ranges from 0 to DEPTH.
- **Output FIFO**
  - Push: `cpu_wr` while `out_count` < DEPTH.
  - Pop: `out_valid && out_ready`.
- **Input FIFO**
  - Push: `in_valid && in_ready`.
  - Pop: `cpu_rd` while `in_count` > 0.
- **Full/empty decisions** use pre-edge occupancy.
  - A push to a full FIFO is dropped, even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged and move both pointers.
  - Push and pop in the same cycle on an empty FIFO: the push succeeds and the pop is void.
    - For the output FIFO this cannot arise, because `out_valid` is 0 when empty.
    - For the input FIFO it is an underflow.
- **Errors**
  - A dropped `cpu_wr` sets `ovf`.
  - `cpu_rd` with `in_count` = 0 sets `udf` and leaves the FIFO unchanged.
  - `err_clr` clears both flags. If a set condition occurs in the same cycle, set wins.
- **Data outputs**
  - `out_data` and `cpu_rdata` are read combinationally from the head entry.
  - Each is forced to 0 when its FIFO is empty.
- **Reset**
  - Pointers, counts, `ovf` and `udf` go to 0.
  - `out_valid` = 0, `out_data` = 0, `cpu_rdata` = 0.
  - `in_ready` is forced to 0 while `reset` is low.
  - Storage contents are not reset.
  - Reset asserted mid-transfer discards all buffered bytes immediately, asynchronously.

## Timing
- CPU write to `out_valid`: 1 cycle, with no fall-through. `out_valid` rises on the edge after the `cpu_wr` edge.
- External push to `cpu_rdata`/`in_count` update: 1 cycle.
- Output sustained throughput: 1 byte/cycle with `out_ready` held high.
- Input sustained throughput: 1 byte/cycle with `in_valid` held high and `cpu_rd` every cycle.
- `in_ready` and `out_valid` depend only on registered counts. They never depend combinationally on `out_ready` or `in_valid`.
- After reset is released, `in_ready` = 1 from the first cycle.

## Configuration
- Macro: `IO_LOOPBACK_EN`.
- **Defined:**
  - The `loopback` port exists.
  - While `loopback` = 1:
    - `out_valid` and `in_ready` are driven 0 externally.
    - Each cycle the output FIFO is not empty and the input FIFO is not full, the output head is popped and pushed into the input FIFO. This is 1 byte/cycle with 1 cycle of latency.
    - External `in_valid` is ignored.
    - CPU `cpu_wr`/`cpu_rd` behave normally.
  - Toggling `loopback` takes effect from the next edge. No byte is lost or duplicated.
- **Undefined:** the port is absent, and behaviour is identical to `loopback` = 0.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream -> counts, `ovf`, `udf`, `out_valid`, `in_ready` all 0 immediately; after release `in_ready` = 1 and `out_count` = 0.
- **Output order and backpressure (DEPTH = 4):** write 0x11, 0x22, 0x33 with `out_ready` = 0 -> `out_count` = 3, `out_data` = 0x11; raise `out_ready` -> 0x11, 0x22, 0x33 appear on consecutive cycles, then `out_valid` = 0.
- **Overflow:** write 0xA0 through 0xA4 (five bytes) with `out_ready` = 0 -> `out_count` = 4, `ovf` = 1, drained sequence A0, A1, A2, A3; write while full with simultaneous pop -> write still dropped.
- **Underflow and clear:** `cpu_rd` on empty input -> `cpu_rdata` = 0, `udf` = 1; `err_clr` -> `udf` = 0; `err_clr` together with a new underflow -> `udf` stays 1.
- **Input wrap-around:** push and pop 10 bytes, 0x01 through 0x0A, through the DEPTH = 4 input FIFO with interleaved simultaneous push/pop -> CPU reads 01 through 0A in order; `in_ready` = 0 exactly while `in_count` = 4.
- **Loopback (`IO_LOOPBACK_EN`):** set `loopback` = 1, write 0x5A, 0xC3 -> `out_valid` stays 0, `in_ready` stays 0, CPU reads 0x5A then 0xC3; clear `loopback` -> external handshakes resume.
